// File: rtl/cell_link_arb_scheduler.sv
// Windowed per-link packet quota scheduler: counts packet ends on two observed streams
// and suppresses a link's arbitration request once its quota for the window is reached.
module cell_link_arb_scheduler (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        enable,
  input  logic [15:0] window_len,
  input  logic [7:0]  s00_quota,
  input  logic [7:0]  s01_quota,
  input  logic        s00_tvalid,
  input  logic        s00_tlast,
  input  logic        s01_tvalid,
  input  logic        s01_tlast,
  output logic        s00_arb_req_suppress,
  output logic        s01_arb_req_suppress,
  output logic [7:0]  s00_pkt_count,
  output logic [7:0]  s01_pkt_count,
  output logic        window_strobe
);

  localparam int unsigned NumLinks = 2;
  localparam logic [7:0] CountMax = 8'hff;

  logic [15:0] win_q, win_d;
  logic [15:0] reload;
  logic        boundary;
  logic        strobe_q, strobe_d;

  logic [NumLinks-1:0] pkt_end;
  logic [NumLinks-1:0] supp_q, supp_d;
  logic [7:0]          quota   [NumLinks];
  logic [7:0]          count_q [NumLinks];
  logic [7:0]          count_d [NumLinks];

  assign pkt_end[0] = s00_tvalid & s00_tlast;
  assign pkt_end[1] = s01_tvalid & s01_tlast;
  assign quota[0]   = s00_quota;
  assign quota[1]   = s01_quota;

  // A zero window length behaves as a one-cycle window.
  assign reload   = (window_len == 16'd0) ? 16'd0 : window_len - 16'd1;
  assign boundary = enable && (win_q == 16'd0);

  always_comb begin
    win_d    = win_q;
    strobe_d = boundary;
    if (!enable || boundary) begin
      win_d = reload;
    end else begin
      win_d = win_q - 16'd1;
    end
  end

  // Boundary reloads the count with this cycle's packet end, so an end landing on the
  // boundary is charged to the new window.
  always_comb begin
    for (int k = 0; k < NumLinks; k++) begin
      count_d[k] = count_q[k];
      supp_d[k]  = 1'b0;
      if (!enable) begin
        count_d[k] = 8'd0;
      end else if (boundary) begin
        count_d[k] = pkt_end[k] ? 8'd1 : 8'd0;
      end else if (pkt_end[k] && (count_q[k] != CountMax)) begin
        count_d[k] = count_q[k] + 8'd1;
      end
      supp_d[k] = enable && (quota[k] != 8'd0) && (count_d[k] >= quota[k]);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      win_q    <= 16'd0;
      strobe_q <= 1'b0;
      supp_q   <= '0;
      for (int k = 0; k < NumLinks; k++) begin
        count_q[k] <= 8'd0;
      end
    end else begin
      win_q    <= win_d;
      strobe_q <= strobe_d;
      supp_q   <= supp_d;
      for (int k = 0; k < NumLinks; k++) begin
        count_q[k] <= count_d[k];
      end
    end
  end

  assign window_strobe        = strobe_q;
  assign s00_arb_req_suppress = supp_q[0];
  assign s01_arb_req_suppress = supp_q[1];
  assign s00_pkt_count        = count_q[0];
  assign s01_pkt_count        = count_q[1];

endmodule

// File: tb/tb_cell_link_arb_scheduler.sv
// Directed self-checking bench for cell_link_arb_scheduler; edges are counted from the
// first rising edge with enable=1, outputs sampled 1 time unit after each edge.
module tb_cell_link_arb_scheduler;

  logic        ACLK;
  logic        ARESETN;
  logic        enable;
  logic [15:0] window_len;
  logic [7:0]  s00_quota, s01_quota;
  logic        s00_tvalid, s00_tlast, s01_tvalid, s01_tlast;
  logic        s00_arb_req_suppress, s01_arb_req_suppress;
  logic [7:0]  s00_pkt_count, s01_pkt_count;
  logic        window_strobe;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cell_link_arb_scheduler u_dut (
    .ACLK                (ACLK),
    .ARESETN             (ARESETN),
    .enable              (enable),
    .window_len          (window_len),
    .s00_quota           (s00_quota),
    .s01_quota           (s01_quota),
    .s00_tvalid          (s00_tvalid),
    .s00_tlast           (s00_tlast),
    .s01_tvalid          (s01_tvalid),
    .s01_tlast           (s01_tlast),
    .s00_arb_req_suppress(s00_arb_req_suppress),
    .s01_arb_req_suppress(s01_arb_req_suppress),
    .s00_pkt_count       (s00_pkt_count),
    .s01_pkt_count       (s01_pkt_count),
    .window_strobe       (window_strobe)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic v0, input logic l0, input logic v1, input logic l1);
    s00_tvalid = v0;
    s00_tlast  = l0;
    s01_tvalid = v1;
    s01_tlast  = l1;
  endtask

  task automatic idle(input int unsigned n);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One disabled edge loads the window counter, then enable rises for edge E1.
  task automatic start_window(input logic [15:0] len, input logic [7:0] q0,
                              input logic [7:0] q1);
    enable     = 1'b0;
    window_len = len;
    s00_quota  = q0;
    s01_quota  = q1;
    idle(1);
    enable = 1'b1;
  endtask

  initial begin
    ARESETN    = 1'b0;
    enable     = 1'b0;
    window_len = 16'd10;
    s00_quota  = 8'd0;
    s01_quota  = 8'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_eq("rst_strobe", window_strobe, 0);
    check_eq("rst_supp0", s00_arb_req_suppress, 0);
    check_eq("rst_supp1", s01_arb_req_suppress, 0);
    check_eq("rst_cnt0", s00_pkt_count, 0);
    check_eq("rst_cnt1", s01_pkt_count, 0);
    ARESETN = 1'b1;
    idle(2);

    // Two 3-beat link-00 packets, quota 2, window 10.
    start_window(16'd10, 8'd2, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); tick();
    check_eq("p37_midpkt_cnt", s00_pkt_count, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    check_eq("p37_cnt_e3", s00_pkt_count, 1);
    check_eq("p37_supp_e3", s00_arb_req_suppress, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); tick();
    check_eq("p37_supp_e5", s00_arb_req_suppress, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    check_eq("p37_cnt_e6", s00_pkt_count, 2);
    check_eq("p37_supp_e6", s00_arb_req_suppress, 1);
    idle(3);
    check_eq("p37_strobe_e9", window_strobe, 0);
    check_eq("p37_supp_e9", s00_arb_req_suppress, 1);
    idle(1);
    check_eq("p37_strobe_e10", window_strobe, 1);
    check_eq("p37_cnt_e10", s00_pkt_count, 0);
    check_eq("p37_supp_e10", s00_arb_req_suppress, 0);
    idle(1);
    check_eq("p37_strobe_e11", window_strobe, 0);

    // Saturation with unlimited quota on link 01.
    start_window(16'd1000, 8'd0, 8'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 254; i++) tick();
    check_eq("p38_cnt_254", s01_pkt_count, 254);
    tick();
    check_eq("p38_cnt_255", s01_pkt_count, 255);
    for (int i = 0; i < 45; i++) tick();
    check_eq("p38_cnt_sat", s01_pkt_count, 255);
    check_eq("p38_supp", s01_arb_req_suppress, 0);
    check_eq("p38_cnt0", s00_pkt_count, 0);

    // Window 8, quota 1: release at boundary, then packet end exactly on a boundary.
    start_window(16'd8, 8'd1, 8'd0);
    idle(4);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    check_eq("p39_supp_e5", s00_arb_req_suppress, 1);
    idle(3);
    check_eq("p39_strobe_e8", window_strobe, 1);
    check_eq("p39_supp_e8", s00_arb_req_suppress, 0);
    idle(7);
    check_eq("p39_cnt_e15", s00_pkt_count, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    check_eq("p39_strobe_e16", window_strobe, 1);
    check_eq("p39_cnt_e16", s00_pkt_count, 1);
    check_eq("p39_supp_e16", s00_arb_req_suppress, 1);

    // Both links at quota 1 together.
    start_window(16'd6, 8'd1, 8'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1); tick();
    check_eq("p40_supp0", s00_arb_req_suppress, 1);
    check_eq("p40_supp1", s01_arb_req_suppress, 1);
    idle(4);
    check_eq("p40_cnt0_e5", s00_pkt_count, 1);
    check_eq("p40_supp1_e5", s01_arb_req_suppress, 1);
    idle(1);
    check_eq("p40_rel0", s00_arb_req_suppress, 0);
    check_eq("p40_rel1", s01_arb_req_suppress, 0);
    check_eq("p40_cnt1_e6", s01_pkt_count, 0);

    // Quota changes; tlast without tvalid must not count.
    start_window(16'd20, 8'd5, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1); tick();
    check_eq("q_novalid", s00_pkt_count, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick(); tick(); tick();
    check_eq("q_cnt3", s00_pkt_count, 3);
    check_eq("q_supp_q5", s00_arb_req_suppress, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    s00_quota = 8'd3; tick();
    check_eq("q_lowered", s00_arb_req_suppress, 1);
    s00_quota = 8'd0; tick();
    check_eq("q_unlimited", s00_arb_req_suppress, 0);

    // Disable while suppressed, re-enable, window_len change mid-window.
    start_window(16'd5, 8'd1, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    check_eq("p41_supp", s00_arb_req_suppress, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0; tick();
    check_eq("p41_off_supp", s00_arb_req_suppress, 0);
    check_eq("p41_off_cnt", s00_pkt_count, 0);
    enable = 1'b1; tick();
    window_len = 16'd3;
    idle(3);
    check_eq("p41_strobe_e4", window_strobe, 0);
    idle(1);
    check_eq("p41_strobe_e5", window_strobe, 1);
    idle(2);
    check_eq("p28_strobe_e7", window_strobe, 0);
    idle(1);
    check_eq("p28_strobe_e8", window_strobe, 1);

    // Asynchronous reset mid-packet with count 5.
    start_window(16'd100, 8'd3, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_eq("p42_pre_cnt", s00_pkt_count, 5);
    check_eq("p42_pre_supp", s00_arb_req_suppress, 1);
    #2 ARESETN = 1'b0;
    #1;
    check_eq("p42_cnt", s00_pkt_count, 0);
    check_eq("p42_supp", s00_arb_req_suppress, 0);
    #1 ARESETN = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("p35_first_strobe", window_strobe, 1);
    check_eq("p36_cnt", s00_pkt_count, 0);
    tick();
    check_eq("p35_strobe_off", window_strobe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
